// File: rtl/float_to_double_if.sv
// Operand/result bundle for the single-to-double converter.
// start is taken on a rising edge only while busy=0; done pulses one cycle with double/invalid valid.
interface float_to_double_if;
  logic        start;
  logic [31:0] float;
  logic [63:0] double;
  logic        busy;
  logic        done;
  logic        invalid;

  modport master (
    output start, float,
    input  double, busy, done, invalid
  );

  modport slave (
    input  start, float,
    output double, busy, done, invalid
  );
endinterface

// File: rtl/float_to_double.sv
// IEEE-754 binary32 -> binary64 widening converter; subnormals are normalised one bit per clock.
module float_to_double (
  input  logic                clk,
  input  logic                reset,
  float_to_double_if.slave    bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLASSIFY  = 2'd1,
    S_NORMALIZE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [22:0] frac_q, frac_d;
  logic [23:0] m_q, m_d;
  logic [4:0]  k_q, k_d;
  logic        sub_q, sub_d;
  logic [63:0] double_q, double_d;
  logic        invalid_q, invalid_d;

  logic [63:0] direct_res;
  logic        direct_inv;

  // Result for every non-subnormal class, built from the latched operand fields.
  always_comb begin
    direct_res = {sign_q, 63'd0};
    direct_inv = 1'b0;
    if (exp_q == 8'hFF) begin
      if (frac_q == 23'd0) begin
        direct_res = {sign_q, 11'h7FF, 52'd0};
      end else begin
        direct_res = {sign_q, 11'h7FF, 1'b1, frac_q[21:0], 29'd0};
        direct_inv = ~frac_q[22];
      end
    end else if (exp_q != 8'h00) begin
      direct_res = {sign_q, {3'd0, exp_q} + 11'd896, frac_q, 29'd0};
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    m_d       = m_q;
    k_d       = k_q;
    sub_d     = sub_q;
    double_d  = double_q;
    invalid_d = invalid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sign_d    = bus.float[31];
          exp_d     = bus.float[30:23];
          frac_d    = bus.float[22:0];
          invalid_d = 1'b0;
          state_d   = S_CLASSIFY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLASSIFY: begin
        k_d     = 5'd0;
        state_d = S_NORMALIZE;
        if (exp_q == 8'h00 && frac_q != 23'd0) begin
          sub_d = 1'b1;
          m_d   = {1'b0, frac_q};
        end else begin
          // Non-subnormals arrive already "normalised" and leave on the next edge.
          sub_d = 1'b0;
          m_d   = 24'h800000;
        end
      end
      S_NORMALIZE: begin
        if (m_q[23]) begin
          state_d = S_DONE;
          if (sub_q) begin
            double_d  = {sign_q, 11'd897 - {6'd0, k_q}, m_q[22:0], 29'd0};
            invalid_d = 1'b0;
          end else begin
            double_d  = direct_res;
            invalid_d = direct_inv;
          end
        end else begin
          m_d = {m_q[22:0], 1'b0};
          k_d = k_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= 8'd0;
      frac_q    <= 23'd0;
      m_q       <= 24'd0;
      k_q       <= 5'd0;
      sub_q     <= 1'b0;
      double_q  <= 64'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      m_q       <= m_d;
      k_q       <= k_d;
      sub_q     <= sub_d;
      double_q  <= double_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.double  = double_q;
  assign bus.invalid = invalid_q;
  assign bus.busy    = (state_q == S_CLASSIFY) || (state_q == S_NORMALIZE);
  assign bus.done    = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_float_to_double.sv
// Directed and randomized checks of float_to_double against an arithmetic reference model.
module tb_float_to_double;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks_total;
  int         checks_passed;
  int         checks_failed;

  float_to_double_if bus ();

  float_to_double dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level model: subnormal = frac * 2^-149, normal exponent rebiased 127 -> 1023.
  function automatic void ref_model(input logic [31:0] f, output logic [63:0] d,
                                    output logic inv, output int lat);
    int          e;
    int          p;
    logic [22:0] m;
    logic [63:0] wide;
    e   = int'(f[30:23]);
    m   = f[22:0];
    inv = 1'b0;
    lat = 2;
    if (e == 255) begin
      if (m == 23'd0) d = {f[31], 11'h7FF, 52'd0};
      else begin
        d   = {f[31], 11'h7FF, 1'b1, m[21:0], 29'd0};
        inv = (m[22] == 1'b0);
      end
    end else if (e == 0) begin
      if (m == 23'd0) d = {f[31], 63'd0};
      else begin
        p = 0;
        for (int i = 0; i < 23; i++) if (m[i]) p = i;
        wide = 64'(m) << (52 - p);
        d    = {f[31], 11'(p - 149 + 1023), wide[51:0]};
        lat  = 2 + (23 - p);
      end
    end else begin
      d = {f[31], 11'(e - 127 + 1023), m, 29'd0};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] f);
    bus.start = 1'b1;
    bus.float = f;
    tick();
    bus.start = 1'b0;
    bus.float = $urandom;
  endtask

  task automatic wait_done(input int n0, output int lat);
    lat = n0;
    while (bus.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] f);
    logic [63:0] exp_d;
    logic        exp_inv;
    int          exp_lat;
    int          lat;
    ref_model(f, exp_d, exp_inv, exp_lat);
    launch(f);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(0, lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_double"}, bus.double, exp_d);
    check({tag, "_invalid"}, 64'(bus.invalid), 64'(exp_inv));
  endtask

  initial begin
    logic [63:0] exp_d;
    logic        exp_inv;
    int          exp_lat;
    int          lat;
    int          dones;
    logic [31:0] f;
    logic [63:0] held;

    checks_total  = 0;
    checks_passed = 0;
    checks_failed = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.float = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_double", bus.double, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_invalid", 64'(bus.invalid), 64'd0);
    reset = 1'b1;
    tick();

    // Directed classes; consecutive calls restart in the DONE cycle.
    run_one("one", 32'h3F800000);
    check("one_value", bus.double, 64'h3FF0000000000000);
    run_one("neg_zero", 32'h80000000);
    run_one("neg_inf", 32'hFF800000);
    run_one("sub_k1", 32'h00400000);
    check("sub_k1_value", bus.double, 64'h3800000000000000);
    run_one("sub_k23", 32'h00000001);
    check("sub_k23_value", bus.double, 64'h36A0000000000000);
    run_one("snan", 32'h7F800001);
    check("snan_value", bus.double, 64'h7FF8000020000000);
    run_one("qnan", 32'h7FC00000);
    held = bus.double;
    tick();
    check("done_pulse", 64'(bus.done), 64'd0);
    check("double_held", bus.double, held);

    // A start while busy is dropped; only the subnormal finishes.
    ref_model(32'h00000001, exp_d, exp_inv, exp_lat);
    launch(32'h00000001);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.float = 32'h3F800000;
    tick();
    bus.start = 1'b0;
    wait_done(5, lat);
    check("ignored_latency", 64'(lat), 64'(exp_lat));
    check("ignored_double", bus.double, exp_d);
    dones = 0;
    repeat (6) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("ignored_no_extra_done", 64'(dones), 64'd0);

    // Abort in the middle of normalisation.
    launch(32'h00000001);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("abort_double", bus.double, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    tick();
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_one("after_abort", 32'h3F800000);

    // Randomized mix, weighted toward subnormals and NaNs.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: f = $urandom;
        1: f = {1'($urandom), 8'h00, 23'($urandom) >> $urandom_range(0, 22)};
        2: f = {1'($urandom), 8'hFF, 23'($urandom)};
        default: f = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      run_one($sformatf("rand%0d_%h", i, f), f);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
